vis_framebuf: RTL and testbench
===============================

# vis_framebuf

- Multi-bank visibility frame buffer between the visibility accumulator and the host-facing AXI4-Stream.
- Write side: accepts one full-width complex visibility per cycle, one frame = CORES×TRATE beats, and commits each complete frame to a free bank.
- Read side: streams committed frames in order with correct valid/ready/last handshaking.
- Generalises the fixed two-bank output store: any bank count, whole-frame drop on overflow, frame-length checking, status counters.

## Interface

- ACCUM, 36: bit-width of each of the real and imaginary visibility parts.
- CORES, 18: correlator cores contributing per time-slot.
- TRATE, 30: time-multiplexing rate. TOTAL = CORES×TRATE beats per frame.
- BANKS, 2: number of frame banks, ≥2. BBITS = $clog2(BANKS).
- DBITS, 8: width of the dropped-frame counter.

Ports:

- clock, in, 1: single clock for all logic.
- reset, in, 1: synchronous, active-high.
- clear_i, in, 1: clears overflow_o, error_o and drops_o; buffer contents are unaffected.
- valid_i, in, 1: input beat valid; the input has no back-pressure.
- last_i, in, 1: final beat of a frame.
- revis_i / imvis_i, in, ACCUM each: visibility real and imaginary parts.
- m_valid_o, out, 1: output beat valid.
- m_ready_i, in, 1: downstream ready.
- m_last_o, out, 1: final beat of an output frame.
- m_revis_o / m_imvis_o, out, ACCUM each: output visibility.
- frame_o, out, 1: one-cycle pulse when a frame is committed.
- level_o, out, BBITS+1: number of committed, unread banks.
- overflow_o, out, 1: sticky; a frame was dropped because all banks were full.
- error_o, out, 1: sticky; a frame-length error occurred.
- drops_o, out, DBITS: saturating count of dropped frames, for any cause.

## Operation

Write side:
- Counters: waddr (0..TOTAL-1) and wbank.
- The first beat of a frame is any valid beat with waddr==0. On that beat, the frame is marked "keep" if level<BANKS, and "drop" otherwise. The mark holds until last_i.
- A bank freed during a dropped frame does not resume writing; the whole frame stays dropped.
- Kept beats write {wbank, waddr}.
- Commit condition: last_i with waddr==TOTAL-1 on a kept frame. On commit, wbank advances modulo BANKS, level increments and frame_o pulses.
- Short frame (last_i with waddr<TOTAL-1):
  - set error_o;
  - discard the frame;
  - increment drops_o;
  - reset waddr to 0.
- Long frame (valid beat at waddr==TOTAL-1 without last_i):
  - set error_o;
  - discard the frame;
  - increment drops_o once;
  - ignore beats until last_i inclusive;
  - then reset waddr to 0.
- A capacity drop sets overflow_o and increments drops_o once, at last_i.
- drops_o saturates at all-ones.
- clear_i has priority over a same-cycle set.

Read side:
- Counters: raddr and rbank.
- Reads start when level>0.
- The output stage is a 2-entry pipe (synchronous RAM read plus a skid register). It sustains one beat per cycle while m_ready_i is high, including across back-to-back frames.
- m_last_o is high on the beat with raddr==TOTAL-1.
- A handshake on the last beat frees the bank: rbank advances modulo BANKS and level decrements.
- Commit and free in the same cycle leave level unchanged.
- While m_valid_o is high and m_ready_i is low, all m_* outputs hold stable.

Reset:
- All counters, level, flags and the output pipe return to 0.
- Buffered frames are discarded, including on reset mid-frame or mid-readout.
- After reset, m_valid_o=0, m_last_o=0, m_revis_o=m_imvis_o=0, frame_o=0, level_o=0, overflow_o=0, error_o=0, drops_o=0.

## Timing

- Last beat sampled at edge k: frame_o and level_o update after edge k.
- First output beat: m_valid_o high after edge k+2.
- Within a frame, with m_ready_i held high: output beat n+1 follows beat n on consecutive cycles.
- A bank is reusable by a frame whose first beat arrives at least one cycle after the freeing handshake.
- Memory: BANKS<<OBITS words, OBITS = $clog2(TOTAL), word width 2×ACCUM, addressed by {bank, addr}.

## Structure

- Shared package vis_pkg holds:
  - TOTAL, OBITS, BBITS localparam functions;
  - the packed complex-visibility type {re, im}.
- Sub-module vis_sram: simple dual-port RAM, one write port and one synchronous-read port, same clock. It is parametrised by width and depth and is reused elsewhere.
- Write control, level/bank bookkeeping and the read pipe stay in vis_framebuf.

## Test plan

All scenarios use CORES=2, TRATE=3 (TOTAL=6), BANKS=2, ACCUM=36.

- Single frame, values 1..6, m_ready_i high → m_valid_o rises 2 cycles after the last write; 6 consecutive beats 1..6 with m_last_o on 6; level_o goes 0→1→0.
- Back-pressure: m_ready_i toggles 1,0,0,1 → no beat is lost or duplicated, outputs stay stable while stalled, and order is preserved.
- Three frames back-to-back with m_ready_i low → frames 1 and 2 are stored and level_o=2; frame 3 is dropped, overflow_o=1, drops_o=1. After draining, output is exactly frames 1 then 2.
- Short frame (last_i on beat 4), then a good frame → error_o=1, drops_o=1, no frame_o on the short frame; the good frame is output intact.
- Long frame (8 beats, last_i on beat 8) → error_o=1, drops_o=1; the next 6-beat frame is committed correctly.
- Reset asserted mid-readout (beat 3) with one frame queued → all outputs and level_o are 0 next cycle; a subsequent frame streams correctly from bank 0.

Source files
------------

// File: rtl/vis_pkg.sv
// Shared sizing helpers and the packed complex-visibility type for the visibility datapath.
package vis_pkg;

  localparam int unsigned ACCUM_W = 36;

  typedef struct packed {
    logic [ACCUM_W-1:0] re;
    logic [ACCUM_W-1:0] im;
  } vis_t;

  function automatic int unsigned total_f(input int unsigned cores, input int unsigned trate);
    return cores * trate;
  endfunction

  function automatic int unsigned obits_f(input int unsigned total);
    return (total > 1) ? $clog2(total) : 1;
  endfunction

  function automatic int unsigned bbits_f(input int unsigned banks);
    return (banks > 1) ? $clog2(banks) : 1;
  endfunction

endpackage

// File: rtl/vis_sram.sv
// Simple dual-port RAM: one write port, one synchronous-read port, single clock.
module vis_sram #(
  parameter int unsigned WIDTH = 72,
  parameter int unsigned DEPTH = 64,
  parameter int unsigned ABITS = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clock,
  input  logic             wr_en_i,
  input  logic [ABITS-1:0] wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  input  logic [ABITS-1:0] rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;

  always_ff @(posedge clock) begin
    if (wr_en_i) r_mem[wr_addr_i] <= wr_data_i;
    if (rd_en_i) r_rd_data <= r_mem[rd_addr_i];
  end

  assign rd_data_o = r_rd_data;

endmodule

// File: rtl/vis_framebuf.sv
// Multi-bank visibility frame buffer: commits whole frames into free banks and
// streams them out in order over a valid/ready interface with a 2-entry output pipe.
module vis_framebuf
  import vis_pkg::*;
#(
  parameter int unsigned ACCUM = ACCUM_W,
  parameter int unsigned CORES = 18,
  parameter int unsigned TRATE = 30,
  parameter int unsigned BANKS = 2,
  parameter int unsigned DBITS = 8
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                clear_i,
  input  logic                                valid_i,
  input  logic                                last_i,
  input  logic [ACCUM-1:0]                    revis_i,
  input  logic [ACCUM-1:0]                    imvis_i,
  output logic                                m_valid_o,
  input  logic                                m_ready_i,
  output logic                                m_last_o,
  output logic [ACCUM-1:0]                    m_revis_o,
  output logic [ACCUM-1:0]                    m_imvis_o,
  output logic                                frame_o,
  output logic [bbits_f(BANKS):0]             level_o,
  output logic                                overflow_o,
  output logic                                error_o,
  output logic [DBITS-1:0]                    drops_o
);

  localparam int unsigned TOTAL = total_f(CORES, TRATE);
  localparam int unsigned OBITS = obits_f(TOTAL);
  localparam int unsigned BBITS = bbits_f(BANKS);
  localparam int unsigned AW    = BBITS + OBITS;
  localparam int unsigned DW    = 2 * ACCUM;
  localparam int unsigned DEPTH = BANKS << OBITS;

  localparam logic [OBITS-1:0] LAST_ADDR = OBITS'(TOTAL - 1);
  localparam logic [BBITS-1:0] LAST_BANK = BBITS'(BANKS - 1);
  localparam logic [BBITS:0]   BANKS_L   = (BBITS + 1)'(BANKS);

  // write-side state
  logic [OBITS-1:0] r_waddr;
  logic [BBITS-1:0] r_wbank;
  logic             r_keep;
  logic             r_skip;
  logic [BBITS:0]   r_level;
  logic             r_frame;
  logic             r_overflow;
  logic             r_error;
  logic [DBITS-1:0] r_drops;

  // read-side state
  logic [OBITS-1:0] r_raddr;
  logic [BBITS-1:0] r_rbank;
  logic [BBITS:0]   r_pend;
  logic             r_rd_v;
  logic             r_rd_last;
  logic             r_out_v;
  logic             r_out_last;
  logic [DW-1:0]    r_out_data;
  logic             r_skid_v;
  logic             r_skid_last;
  logic [DW-1:0]    r_skid_data;

  logic             w_beat;
  logic             w_first;
  logic             w_keep;
  logic             w_at_end;
  logic             w_wr_en;
  logic             w_commit;
  logic             w_short;
  logic             w_long;
  logic             w_drop;
  logic             w_pop;
  logic             w_free;
  logic [1:0]       w_occ;
  logic             w_fetch;
  logic             w_fetch_last;
  logic [DW-1:0]    w_rd_data;

  // Frame classification: keep/drop is decided once on the first beat and held.
  always_comb begin
    w_beat   = valid_i && !r_skip;
    w_first  = (r_waddr == '0) && !r_skip;
    w_keep   = w_first ? (r_level < BANKS_L) : r_keep;
    w_at_end = (r_waddr == LAST_ADDR);
    w_wr_en  = w_beat && w_keep;
    w_commit = w_beat && last_i && w_at_end && w_keep;
    w_short  = w_beat && last_i && !w_at_end;
    w_long   = w_beat && !last_i && w_at_end;
    w_drop   = w_short || w_long || (w_beat && last_i && w_at_end && !w_keep);
  end

  // Read issue: a fetch is allowed only if the pipe can absorb it next cycle.
  always_comb begin
    w_pop        = r_out_v && m_ready_i;
    w_free       = w_pop && r_out_last;
    w_occ        = 2'(r_out_v) + 2'(r_skid_v) + 2'(r_rd_v) - 2'(w_pop);
    w_fetch      = (r_pend != '0) && (w_occ < 2'd2);
    w_fetch_last = w_fetch && (r_raddr == LAST_ADDR);
  end

  vis_sram #(
    .WIDTH (DW),
    .DEPTH (DEPTH),
    .ABITS (AW)
  ) u_sram (
    .clock     (clock),
    .wr_en_i   (w_wr_en),
    .wr_addr_i ({r_wbank, r_waddr}),
    .wr_data_i ({revis_i, imvis_i}),
    .rd_en_i   (w_fetch),
    .rd_addr_i ({r_rbank, r_raddr}),
    .rd_data_o (w_rd_data)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_waddr    <= '0;
      r_wbank    <= '0;
      r_keep     <= 1'b0;
      r_skip     <= 1'b0;
      r_frame    <= 1'b0;
      r_overflow <= 1'b0;
      r_error    <= 1'b0;
      r_drops    <= '0;
    end else begin
      r_frame <= w_commit;
      if (valid_i) begin
        if (r_skip) begin
          if (last_i) r_skip <= 1'b0;
        end else begin
          if (w_first) r_keep <= w_keep;
          if (last_i || w_at_end) r_waddr <= '0;
          else                    r_waddr <= r_waddr + OBITS'(1);
          if (w_long) r_skip <= 1'b1;
          if (w_commit) r_wbank <= (r_wbank == LAST_BANK) ? '0 : r_wbank + BBITS'(1);
        end
      end
      if (clear_i) begin
        r_overflow <= 1'b0;
        r_error    <= 1'b0;
        r_drops    <= '0;
      end else begin
        if (w_drop && !w_keep) r_overflow <= 1'b1;
        if (w_short || w_long) r_error <= 1'b1;
        if (w_drop && (r_drops != '1)) r_drops <= r_drops + DBITS'(1);
      end
    end
  end

  // Level counts committed-but-unfreed banks; pend counts committed-but-unfetched ones.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_level <= '0;
      r_pend  <= '0;
    end else begin
      case ({w_commit, w_free})
        2'b10:   r_level <= r_level + (BBITS + 1)'(1);
        2'b01:   r_level <= r_level - (BBITS + 1)'(1);
        default: r_level <= r_level;
      endcase
      case ({w_commit, w_fetch_last})
        2'b10:   r_pend <= r_pend + (BBITS + 1)'(1);
        2'b01:   r_pend <= r_pend - (BBITS + 1)'(1);
        default: r_pend <= r_pend;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_raddr     <= '0;
      r_rbank     <= '0;
      r_rd_v      <= 1'b0;
      r_rd_last   <= 1'b0;
      r_out_v     <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
      r_skid_v    <= 1'b0;
      r_skid_last <= 1'b0;
      r_skid_data <= '0;
    end else begin
      r_rd_v    <= w_fetch;
      r_rd_last <= w_fetch_last;
      if (w_fetch) begin
        if (w_fetch_last) begin
          r_raddr <= '0;
          r_rbank <= (r_rbank == LAST_BANK) ? '0 : r_rbank + BBITS'(1);
        end else begin
          r_raddr <= r_raddr + OBITS'(1);
        end
      end
      // Output register refills from the skid first so order is preserved.
      if (!r_out_v || w_pop) begin
        if (r_skid_v) begin
          r_out_v     <= 1'b1;
          r_out_data  <= r_skid_data;
          r_out_last  <= r_skid_last;
          r_skid_v    <= r_rd_v;
          r_skid_data <= w_rd_data;
          r_skid_last <= r_rd_last;
        end else if (r_rd_v) begin
          r_out_v    <= 1'b1;
          r_out_data <= w_rd_data;
          r_out_last <= r_rd_last;
        end else begin
          r_out_v    <= 1'b0;
          r_out_last <= 1'b0;
        end
      end else if (r_rd_v) begin
        r_skid_v    <= 1'b1;
        r_skid_data <= w_rd_data;
        r_skid_last <= r_rd_last;
      end
    end
  end

  assign m_valid_o  = r_out_v;
  assign m_last_o   = r_out_last;
  assign m_revis_o  = r_out_data[DW-1:ACCUM];
  assign m_imvis_o  = r_out_data[ACCUM-1:0];
  assign frame_o    = r_frame;
  assign level_o    = r_level;
  assign overflow_o = r_overflow;
  assign error_o    = r_error;
  assign drops_o    = r_drops;

endmodule

// File: tb/tb_vis_framebuf.sv
// Directed bench for vis_framebuf with TOTAL=6, BANKS=2, ACCUM=36.
module tb_vis_framebuf;
  import vis_pkg::*;

  localparam int unsigned ACCUM = 36;
  localparam int unsigned TOTAL = 6;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              clear_i = 1'b0;
  logic              valid_i = 1'b0;
  logic              last_i = 1'b0;
  logic [ACCUM-1:0]  revis_i = '0;
  logic [ACCUM-1:0]  imvis_i = '0;
  logic              m_valid_o;
  logic              m_ready_i = 1'b0;
  logic              m_last_o;
  logic [ACCUM-1:0]  m_revis_o;
  logic [ACCUM-1:0]  m_imvis_o;
  logic              frame_o;
  logic [1:0]        level_o;
  logic              overflow_o;
  logic              error_o;
  logic [7:0]        drops_o;

  int n_tests = 0;
  int n_fail  = 0;
  int n_frames = 0;

  logic [ACCUM-1:0] q_re[$];
  logic [ACCUM-1:0] q_im[$];
  logic             q_last[$];

  vis_framebuf #(
    .ACCUM (ACCUM),
    .CORES (2),
    .TRATE (3),
    .BANKS (2),
    .DBITS (8)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .clear_i    (clear_i),
    .valid_i    (valid_i),
    .last_i     (last_i),
    .revis_i    (revis_i),
    .imvis_i    (imvis_i),
    .m_valid_o  (m_valid_o),
    .m_ready_i  (m_ready_i),
    .m_last_o   (m_last_o),
    .m_revis_o  (m_revis_o),
    .m_imvis_o  (m_imvis_o),
    .frame_o    (frame_o),
    .level_o    (level_o),
    .overflow_o (overflow_o),
    .error_o    (error_o),
    .drops_o    (drops_o)
  );

  always #5 clock = ~clock;

  // Handshakes and frame pulses are recorded on the falling edge.
  always @(negedge clock) begin
    if (!reset && m_valid_o && m_ready_i) begin
      q_re.push_back(m_revis_o);
      q_im.push_back(m_imvis_o);
      q_last.push_back(m_last_o);
    end
    if (!reset && frame_o) n_frames++;
  end

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) tick();
  endtask

  // Beat i carries re = base+i+1, im = re+256; last_i on beat number last_at.
  task automatic send_frame(input int base, input int nbeats, input int last_at);
    for (int i = 0; i < nbeats; i++) begin
      valid_i = 1'b1;
      last_i  = (i == last_at - 1);
      revis_i = ACCUM'(base + i + 1);
      imvis_i = ACCUM'(base + i + 1 + 256);
      tick();
    end
    valid_i = 1'b0;
    last_i  = 1'b0;
  endtask

  task automatic expect_frames(input string tag, input int mark, input int b0, input int b1, input int nf);
    int n;
    n = nf * TOTAL;
    chk({tag, "_count"}, 72'(q_re.size() - mark), 72'(n));
    for (int i = 0; i < n; i++) begin
      int b;
      int v;
      if (mark + i < q_re.size()) begin
        b = (i < TOTAL) ? b0 : b1;
        v = b + (i % TOTAL) + 1;
        chk({tag, "_data"}, {q_re[mark+i], q_im[mark+i]}, {ACCUM'(v), ACCUM'(v + 256)});
        chk({tag, "_last"}, 72'(q_last[mark+i]), 72'((i % TOTAL) == TOTAL - 1));
      end
    end
  endtask

  task automatic pulse_clear();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
  endtask

  initial begin
    int mark;
    int fcnt;
    logic [3:0] pat;

    // Reset values
    wait_cycles(2);
    chk("rst_valid", 72'(m_valid_o), 72'(0));
    chk("rst_last", 72'(m_last_o), 72'(0));
    chk("rst_data", {m_revis_o, m_imvis_o}, 72'(0));
    chk("rst_level", 72'(level_o), 72'(0));
    chk("rst_flags", {69'(drops_o), overflow_o, error_o, frame_o}, 72'(0));
    reset = 1'b0;
    tick();

    // Single frame, latency and consecutive beats
    m_ready_i = 1'b1;
    send_frame(0, 6, 6);
    chk("s1_frame", 72'(frame_o), 72'(1));
    chk("s1_level1", 72'(level_o), 72'(1));
    chk("s1_valid_k", 72'(m_valid_o), 72'(0));
    tick();
    chk("s1_valid_k1", 72'(m_valid_o), 72'(0));
    chk("s1_frame_pulse", 72'(frame_o), 72'(0));
    tick();
    for (int b = 1; b <= 6; b++) begin
      chk("s1_beat_valid", 72'(m_valid_o), 72'(1));
      chk("s1_beat_data", {m_revis_o, m_imvis_o}, {ACCUM'(b), ACCUM'(b + 256)});
      chk("s1_beat_last", 72'(m_last_o), 72'(b == 6));
      tick();
    end
    chk("s1_level0", 72'(level_o), 72'(0));
    chk("s1_valid_end", 72'(m_valid_o), 72'(0));

    // Back-pressure with ready pattern 1,0,0,1
    mark = q_re.size();
    m_ready_i = 1'b0;
    send_frame(10, 6, 6);
    wait_cycles(2);
    pat = 4'b1001;
    for (int c = 0; c < 32; c++) begin
      logic stall;
      int idx;
      m_ready_i = pat[c % 4];
      stall = m_valid_o && !m_ready_i;
      tick();
      if (stall) begin
        idx = q_re.size() - mark;
        chk("s2_stall_valid", 72'(m_valid_o), 72'(1));
        chk("s2_stall_data", {m_revis_o, m_imvis_o}, {ACCUM'(10 + idx + 1), ACCUM'(10 + idx + 1 + 256)});
        chk("s2_stall_last", 72'(m_last_o), 72'(idx == 5));
      end
    end
    expect_frames("s2", mark, 10, 0, 1);

    // Overflow: three frames with ready low
    mark = q_re.size();
    m_ready_i = 1'b0;
    send_frame(20, 6, 6);
    send_frame(30, 6, 6);
    send_frame(40, 6, 6);
    chk("s3_level", 72'(level_o), 72'(2));
    chk("s3_overflow", 72'(overflow_o), 72'(1));
    chk("s3_drops", 72'(drops_o), 72'(1));
    chk("s3_error", 72'(error_o), 72'(0));
    m_ready_i = 1'b1;
    wait_cycles(20);
    expect_frames("s3", mark, 20, 30, 2);
    chk("s3_level_drained", 72'(level_o), 72'(0));
    pulse_clear();
    chk("s3_clear_ovf", 72'(overflow_o), 72'(0));
    chk("s3_clear_drops", 72'(drops_o), 72'(0));

    // Short frame then a good frame
    mark = q_re.size();
    fcnt = n_frames;
    send_frame(50, 4, 4);
    chk("s4_no_frame", 72'(frame_o), 72'(0));
    chk("s4_error", 72'(error_o), 72'(1));
    chk("s4_drops", 72'(drops_o), 72'(1));
    send_frame(60, 6, 6);
    chk("s4_good_frame", 72'(frame_o), 72'(1));
    wait_cycles(12);
    expect_frames("s4", mark, 60, 0, 1);
    chk("s4_frame_count", 72'(n_frames - fcnt), 72'(1));
    pulse_clear();
    chk("s4_clear_err", 72'(error_o), 72'(0));

    // Long frame (8 beats) then a good frame
    mark = q_re.size();
    fcnt = n_frames;
    send_frame(70, 8, 8);
    chk("s5_error", 72'(error_o), 72'(1));
    chk("s5_drops", 72'(drops_o), 72'(1));
    chk("s5_no_frame", 72'(n_frames - fcnt), 72'(0));
    send_frame(80, 6, 6);
    wait_cycles(12);
    expect_frames("s5", mark, 80, 0, 1);
    chk("s5_level", 72'(level_o), 72'(0));
    pulse_clear();

    // Reset during readout of the third beat with a second frame queued
    m_ready_i = 1'b0;
    send_frame(90, 6, 6);
    send_frame(100, 6, 6);
    wait_cycles(2);
    m_ready_i = 1'b1;
    wait_cycles(2);
    chk("s6_beat3", {m_revis_o, m_imvis_o}, {ACCUM'(93), ACCUM'(93 + 256)});
    reset = 1'b1;
    tick();
    chk("s6_rst_valid", 72'(m_valid_o), 72'(0));
    chk("s6_rst_last", 72'(m_last_o), 72'(0));
    chk("s6_rst_data", {m_revis_o, m_imvis_o}, 72'(0));
    chk("s6_rst_level", 72'(level_o), 72'(0));
    reset = 1'b0;
    mark = q_re.size();
    send_frame(110, 6, 6);
    wait_cycles(12);
    expect_frames("s6", mark, 110, 0, 1);
    chk("s6_level", 72'(level_o), 72'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
